// File: rtl/gen_que_frame_tx.sv
// Frame transmitter: pops payload words from the SRL queue and emits header/payload[/checksum] frames on a valid/ready stream.
// Optional trailing checksum word is built when GEN_QUE_FRAME_CHKSUM_EN is defined.
`timescale 1ns/1ps
module gen_que_frame_tx #(
    parameter int WD = 32,
    parameter int LEN_W = 8,
    parameter logic [WD-LEN_W-1:0] HDR_TAG = 24'hA5C35A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [WD-1:0]    q_dout,
    input  logic             q_ok_to_pop,
    output logic             q_pop,
    output logic [WD-1:0]    m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             abort,
    output logic [15:0]      frame_cnt
);

`ifdef GEN_QUE_FRAME_CHKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHK} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_PAYLOAD} state_t;
`endif

    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_t             state_q;
    logic [WD-1:0]      m_data_q;
    logic               m_valid_q;
    logic               m_last_q;
    logic               abort_q;
    logic [15:0]        frame_cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
    logic [WD-1:0]      sum_q;
`endif

    logic load_ok;
    logic last_pop;

    assign load_ok  = ~m_valid_q | m_ready;
    assign last_pop = (cnt_q == len_q - LEN_ONE);
    // Flush suppresses the pop in the same cycle so no queue word is lost to an aborted frame.
    assign q_pop    = (state_q == S_PAYLOAD) & load_ok & q_ok_to_pop & flush_n;

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != S_IDLE);
    assign abort     = abort_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else if (!flush_n) begin
            abort_q   <= (state_q != S_IDLE) | m_valid_q;
            state_q   <= S_IDLE;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            cnt_q     <= '0;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            abort_q <= 1'b0;
            if (m_valid_q && m_ready && m_last_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            // Accepted word drains unless a new one is loaded below.
            if (load_ok) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable && (frame_len != '0) && q_ok_to_pop && load_ok) begin
                        m_data_q  <= {HDR_TAG, frame_len};
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b0;
                        len_q     <= frame_len;
                        cnt_q     <= '0;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
                        sum_q     <= '0;
`endif
                        state_q   <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (q_pop) begin
                        m_data_q  <= q_dout;
                        m_valid_q <= 1'b1;
                        cnt_q     <= cnt_q + LEN_ONE;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
                        sum_q     <= sum_q + q_dout;
                        m_last_q  <= 1'b0;
                        if (last_pop) begin
                            state_q <= S_CHK;
                        end
`else
                        m_last_q  <= last_pop;
                        if (last_pop) begin
                            state_q <= S_IDLE;
                        end
`endif
                    end
                end
`ifdef GEN_QUE_FRAME_CHKSUM_EN
                S_CHK: begin
                    if (load_ok) begin
                        m_data_q  <= sum_q;
                        m_valid_q <= 1'b1;
                        m_last_q  <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_que_frame_tx.sv
// Self-checking bench for gen_que_frame_tx: directed frame table, multi-cycle corner cases,
// and randomized ready/queue-availability traffic checked against a frame-level stream model.
`timescale 1ns/1ps
module tb_gen_que_frame_tx;
`ifdef GEN_QUE_FRAME_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam logic [23:0] TAG = 24'hA5C35A;

    logic        clk = 1'b0;
    logic        rst_n, flush_n, enable, q_ok_to_pop, q_pop, m_valid, m_last, m_ready, busy, abort;
    logic [7:0]  frame_len;
    logic [31:0] q_dout, m_data;
    logic [15:0] frame_cnt;

    gen_que_frame_tx dut (
        .clk(clk), .rst_n(rst_n), .flush_n(flush_n), .enable(enable), .frame_len(frame_len),
        .q_dout(q_dout), .q_ok_to_pop(q_ok_to_pop), .q_pop(q_pop), .m_data(m_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy), .abort(abort),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int frames_exp = 0;
    logic [31:0] tbq[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    bit          gate = 1'b1;
    bit          rand_mode = 1'b0;
    logic        snap_valid, snap_pop;
    logic [31:0] snap_data;

    typedef struct {
        int          len;
        logic [31:0] w[4];
        logic [31:0] sum;
    } vec_t;
    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int len);
        return {TAG, 8'(len)};
    endfunction

    task automatic drive_q();
        q_ok_to_pop = gate && (tbq.size() > 0);
        q_dout = (tbq.size() > 0) ? tbq[0] : $urandom;
    endtask

    // One clock: observe at negedge, update queue/inputs just after posedge.
    task automatic step();
        logic pop_now;
        @(negedge clk);
        snap_valid = m_valid;
        snap_data  = m_data;
        snap_pop   = q_pop;
        pop_now    = q_pop;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
        if (q_pop) chk("pop_legal", {31'b0, q_ok_to_pop & (~m_valid | m_ready)}, 32'd1);
        @(posedge clk);
        #1;
        if (pop_now && tbq.size() > 0) void'(tbq.pop_front());
        if (rand_mode) begin
            m_ready = ($urandom_range(0, 3) != 0);
            gate    = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 4) != 0);
        end
        drive_q();
    endtask

    // Expected stream for one frame built from its payload words.
    task automatic add_frame(input int len, input logic [31:0] words[$]);
        logic [31:0] sum = 32'd0;
        exp_d.push_back(hdr(len));
        exp_l.push_back(1'b0);
        for (int k = 0; k < len; k++) begin
            sum = sum + words[k];
            exp_d.push_back(words[k]);
            exp_l.push_back((CHK == 0) && (k == len - 1));
        end
        if (CHK != 0) begin
            exp_d.push_back(sum);
            exp_l.push_back(1'b1);
        end
    endtask

    task automatic compare_stream(input string name);
        chk({name, "_len"}, 32'(got_d.size()), 32'(exp_d.size()));
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            chk({name, "_data"}, got_d[k], exp_d[k]);
            chk({name, "_last"}, {31'b0, got_l[k]}, {31'b0, exp_l[k]});
        end
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || m_valid) && n < bound);
        if (busy || m_valid) chk("timeout_idle", 32'(n), 32'(bound + 1));
    endtask

    task automatic start_frame(input int len);
        frame_len = 8'(len);
        enable = 1'b1;
        drive_q();
        step();
        enable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ws[$];
        int lens[5] = '{1, 2, 3, 7, 16};
        int n;

        vt[0] = '{len: 3, w: '{32'd1, 32'd2, 32'd3, 32'd0}, sum: 32'd6};
        vt[1] = '{len: 2, w: '{32'hFFFFFFFF, 32'h2, 32'd0, 32'd0}, sum: 32'h1};
        vt[2] = '{len: 4, w: '{32'd10, 32'd20, 32'd30, 32'd40}, sum: 32'd100};
        vt[3] = '{len: 1, w: '{32'hDEADBEEF, 32'd0, 32'd0, 32'd0}, sum: 32'hDEADBEEF};

        rst_n = 1'b0; flush_n = 1'b1; enable = 1'b0; frame_len = 8'd0; m_ready = 1'b0;
        drive_q();
        repeat (2) @(negedge clk);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_last", {31'b0, m_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_abort", {31'b0, abort}, 32'd0);
        chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("rst_q_pop", {31'b0, q_pop}, 32'd0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        step();

        // frame_len == 0 must never start a frame
        tbq.push_back(32'h55);
        start_frame(0);
        repeat (3) step();
        chk("len0_busy", {31'b0, busy}, 32'd0);
        chk("len0_valid", {31'b0, m_valid}, 32'd0);
        chk("len0_queue", 32'(tbq.size()), 32'd1);
        tbq.delete(); got_d.delete(); got_l.delete(); drive_q();

        for (int i = 0; i < 4; i++) begin
            ws.delete();
            for (int j = 0; j < vt[i].len; j++) begin
                tbq.push_back(vt[i].w[j]);
                ws.push_back(vt[i].w[j]);
            end
            start_frame(vt[i].len);
            repeat (vt[i].len + 1 + CHK) step();
            chk("tbl_consecutive", 32'(got_d.size()), 32'(vt[i].len + 1 + CHK));
            step();
            chk("tbl_idle_valid", {31'b0, m_valid}, 32'd0);
            chk("tbl_idle_busy", {31'b0, busy}, 32'd0);
            frames_exp++;
            chk("tbl_frame_cnt", {16'b0, frame_cnt}, 32'(frames_exp));
            if (CHK != 0) chk("tbl_chksum", got_d[got_d.size() - 1], vt[i].sum);
            add_frame(vt[i].len, ws);
            compare_stream("tbl");
        end

        // Sink stall while payload word 2 is presented
        ws = '{32'd1, 32'd2, 32'd3};
        foreach (ws[k]) tbq.push_back(ws[k]);
        start_frame(3);
        step(); step();
        m_ready = 1'b0;
        repeat (4) begin
            step();
            chk("stall_valid", {31'b0, snap_valid}, 32'd1);
            chk("stall_data", snap_data, 32'd2);
            chk("stall_pop", {31'b0, snap_pop}, 32'd0);
        end
        m_ready = 1'b1;
        run_idle(30);
        frames_exp++;
        add_frame(3, ws);
        compare_stream("stall");
        chk("stall_frame_cnt", {16'b0, frame_cnt}, 32'(frames_exp));

        // Queue runs dry mid-frame, refilled later
        tbq.push_back(32'd7); tbq.push_back(32'd8);
        start_frame(4);
        repeat (12) step();
        chk("empty_partial", 32'(got_d.size()), 32'd3);
        chk("empty_drained", {31'b0, m_valid}, 32'd0);
        chk("empty_busy", {31'b0, busy}, 32'd1);
        tbq.push_back(32'd9); tbq.push_back(32'd10);
        drive_q();
        run_idle(30);
        frames_exp++;
        if (CHK != 0) chk("empty_chksum", got_d[got_d.size() - 1], 32'd34);
        ws = '{32'd7, 32'd8, 32'd9, 32'd10};
        add_frame(4, ws);
        compare_stream("empty");

        // Flush during payload word 2
        ws = '{32'd1, 32'd2, 32'd3};
        foreach (ws[k]) tbq.push_back(ws[k]);
        start_frame(3);
        step(); step();
        flush_n = 1'b0;
        step();
        flush_n = 1'b1;
        chk("flush_pop", {31'b0, snap_pop}, 32'd0);
        chk("flush_valid", {31'b0, m_valid}, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_abort", {31'b0, abort}, 32'd1);
        step();
        chk("flush_abort_once", {31'b0, abort}, 32'd0);
        chk("flush_frame_cnt", {16'b0, frame_cnt}, 32'(frames_exp));
        tbq.delete(); got_d.delete(); got_l.delete(); drive_q();
        ws = '{32'd5, 32'd6};
        foreach (ws[k]) tbq.push_back(ws[k]);
        start_frame(2);
        run_idle(30);
        frames_exp++;
        add_frame(2, ws);
        compare_stream("post_flush");

        // Randomized backpressure and queue availability
        foreach (lens[s]) begin
            for (int f = 0; f < 4; f++) begin
                ws.delete();
                for (int k = 0; k < lens[s]; k++) begin
                    ws.push_back($urandom);
                    tbq.push_back(ws[k]);
                end
                add_frame(lens[s], ws);
            end
            frame_len = 8'(lens[s]);
            rand_mode = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while ((tbq.size() > 0 || busy || m_valid) && n < 5000);
            rand_mode = 1'b0;
            enable = 1'b0; m_ready = 1'b1; gate = 1'b1; drive_q();
            if (n >= 5000) chk("rnd_timeout", 32'(n), 32'd0);
            frames_exp += 4;
            compare_stream("rnd");
            chk("rnd_frame_cnt", {16'b0, frame_cnt}, 32'(frames_exp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
